// File: rtl/s_p_pkg.sv
// Shared types and helpers for the serial-to-parallel frame controller.
package s_p_pkg;

  localparam int C_BITS_OUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LATCH  = 2'd3
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/s_p_bit_counter.sv
// Saturating frame bit counter: clear / load-1 / increment, priority in that order.
// tc_o flags that the next increment completes the frame.
module s_p_bit_counter #(
  parameter int C_MAX = 255,
  parameter int C_W   = 8
) (
  input  logic           clk_i,
  input  logic           srst_i,
  input  logic           clr_i,
  input  logic           load1_i,
  input  logic           inc_i,
  output logic [C_W-1:0] cnt_o,
  output logic           tc_o
);

  logic [C_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = C_W'(1);
    end else if (inc_i && (cnt_q != C_W'(C_MAX))) begin
      cnt_d = cnt_q + C_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == C_W'(C_MAX - 1));

endmodule

// File: rtl/s_p_frame_ctrl.sv
// Frame-aware latch sequencer for the serial-to-parallel converter with valid/ready hand-off.
// Optional trailing even-parity bit check is enabled by defining S_P_PARITY_CHECK_EN.
module s_p_frame_ctrl
  import s_p_pkg::*;
#(
  parameter  int C_BITS_OUT = C_BITS_OUT_DEFAULT,
  localparam int C_CNT_W    = cnt_w(C_BITS_OUT)
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               SIN,
  input  logic               SIN_VALID,
  input  logic               SOF,
  output logic               LATCH_EN,
  output logic               FRAME_VALID,
  input  logic               FRAME_READY,
  output logic               OVERRUN,
  input  logic               OVR_CLR,
  output logic               PARITY_ERR,
  output logic               BUSY,
  output logic [C_CNT_W-1:0] BIT_CNT
);

  state_e state_q, state_d;
  logic   cnt_load1, cnt_inc, cnt_clr, cnt_last;
  logic   fv_q, fv_d, ovr_q, ovr_d;
  logic   latch_fire, ovr_set, sof_acc;

  assign sof_acc = SIN_VALID & SOF;

`ifdef S_P_PARITY_CHECK_EN
  localparam state_e DONE_STATE = PARITY;
  logic par_q, par_d, perr_q, perr_d;
`else
  localparam state_e DONE_STATE = LATCH;
  logic unused_sin;
  assign unused_sin = SIN;
`endif

  s_p_bit_counter #(
    .C_MAX (C_BITS_OUT),
    .C_W   (C_CNT_W)
  ) u_bit_counter (
    .clk_i   (CK),
    .srst_i  (RST),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .cnt_o   (BIT_CNT),
    .tc_o    (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    latch_fire = 1'b0;
    ovr_set    = 1'b0;
`ifdef S_P_PARITY_CHECK_EN
    perr_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sof_acc) begin
          state_d   = SHIFT;
          cnt_load1 = 1'b1;
        end
      end
      SHIFT: begin
        // A fresh SOF silently restarts the frame in place.
        if (sof_acc) begin
          cnt_load1 = 1'b1;
        end else if (SIN_VALID) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = DONE_STATE;
        end
      end
      PARITY: begin
`ifdef S_P_PARITY_CHECK_EN
        if (sof_acc) begin
          state_d   = SHIFT;
          cnt_load1 = 1'b1;
        end else if (SIN_VALID) begin
          if (par_q ^ SIN) begin
            perr_d  = 1'b1;
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            state_d = LATCH;
          end
        end
`else
        state_d = IDLE;
        cnt_clr = 1'b1;
`endif
      end
      LATCH: begin
        // An unconsumed word wins over the new one; the new frame is dropped.
        if (fv_q && !FRAME_READY) ovr_set = 1'b1;
        else                      latch_fire = 1'b1;
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_comb begin
    fv_d = fv_q;
    if (latch_fire)                fv_d = 1'b1;
    else if (fv_q && FRAME_READY)  fv_d = 1'b0;
    ovr_d = ovr_q;
    if (ovr_set)      ovr_d = 1'b1;
    else if (OVR_CLR) ovr_d = 1'b0;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef S_P_PARITY_CHECK_EN
  always_comb begin
    par_d = par_q;
    if (cnt_load1)    par_d = SIN;
    else if (cnt_inc) par_d = par_q ^ SIN;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign PARITY_ERR = perr_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  assign LATCH_EN    = latch_fire;
  assign FRAME_VALID = fv_q;
  assign OVERRUN     = ovr_q;
  assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_s_p_frame_ctrl.sv
// Self-checking bench for s_p_frame_ctrl (C_BITS_OUT=8): table vectors, directed corner sequences,
// and a randomized run against a frame-level reference model.
module tb_s_p_frame_ctrl;

  localparam int N = 8;
  localparam int W = 4;
`ifdef S_P_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic CK = 1'b0;
  logic RST, SIN, SIN_VALID, SOF, FRAME_READY, OVR_CLR;
  logic LATCH_EN, FRAME_VALID, OVERRUN, PARITY_ERR, BUSY;
  logic [W-1:0] BIT_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CK = ~CK;

  s_p_frame_ctrl #(.C_BITS_OUT(N)) dut (
    .CK          (CK),
    .RST         (RST),
    .SIN         (SIN),
    .SIN_VALID   (SIN_VALID),
    .SOF         (SOF),
    .LATCH_EN    (LATCH_EN),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_READY (FRAME_READY),
    .OVERRUN     (OVERRUN),
    .OVR_CLR     (OVR_CLR),
    .PARITY_ERR  (PARITY_ERR),
    .BUSY        (BUSY),
    .BIT_CNT     (BIT_CNT)
  );

  typedef struct {
    logic       rst, sv, sof, sin, rdy, clr;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Output vector layout: {latch_en, frame_valid, overrun, parity_err, busy, bit_cnt[3:0]}
  function automatic logic [8:0] ev(bit le, bit fv, bit ov, bit pe, bit bz, int cnt);
    return {le, fv, ov, pe, bz, 4'(cnt)};
  endfunction

  function automatic void add(logic rst, logic sv, logic sof, logic sin, logic rdy, logic clr,
                              logic [8:0] exp);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sof = sof; v.sin = sin; v.rdy = rdy; v.clr = clr; v.exp = exp;
    tbl.push_back(v);
  endfunction

  // All-zero data frame with READY low; le says whether the latch is expected to fire.
  function automatic void add_frame(bit fv, bit ov, bit le);
    for (int i = 1; i <= N; i++)
      add(0, 1, i == 1, 0, 0, 0, ev((i == N) && !PAR_EN && le, fv, ov, 0, 1, i));
`ifdef S_P_PARITY_CHECK_EN
    add(0, 1, 0, 0, 0, 0, ev(le, fv, ov, 0, 1, N));
`endif
  endfunction

  task automatic drive(input logic rst, input logic sv, input logic sof, input logic sin,
                       input logic rdy, input logic clr);
    RST = rst; SIN_VALID = sv; SOF = sof; SIN = sin; FRAME_READY = rdy; OVR_CLR = clr;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {LATCH_EN, FRAME_VALID, OVERRUN, PARITY_ERR, BUSY, BIT_CNT};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {le,fv,ovr,perr,busy,cnt} got %b_%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%b_%0d",
               name, act[8], act[7], act[6], act[5], act[4], act[3:0],
               exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input bit first_sof, input logic rdy);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, first_sof && (i == 0), d[i], rdy, 0);
      tick();
    end
  endtask

  // Frame-level reference: progress count, running parity, pending latch decision.
  int m_cnt;
  bit m_par, m_latch, m_fv, m_ovr, m_perr;

  function automatic bit m_le(bit rdy);
    return m_latch && !(m_fv && !rdy);
  endfunction

  function automatic void model_step(bit rst, bit sv, bit sof, bit sin, bit rdy, bit clr);
    bit le;
    le = m_le(rdy);
    if (rst) begin
      m_cnt = 0; m_par = 0; m_latch = 0; m_fv = 0; m_ovr = 0; m_perr = 0;
      return;
    end
    m_ovr  = (m_latch && m_fv && !rdy) ? 1'b1 : (clr ? 1'b0 : m_ovr);
    m_fv   = le ? 1'b1 : ((m_fv && rdy) ? 1'b0 : m_fv);
    m_perr = 0;
    if (m_latch) begin
      m_latch = 0;
      m_cnt   = 0;
    end else if (sv && sof) begin
      m_cnt = 1;
      m_par = sin;
    end else if (sv && m_cnt > 0) begin
      if (m_cnt < N) begin
        m_cnt++;
        m_par ^= sin;
        if (m_cnt == N && !PAR_EN) m_latch = 1;
      end else if (m_par ^ sin) begin
        m_perr = 1;
        m_cnt  = 0;
      end else begin
        m_latch = 1;
      end
    end
  endfunction

  initial begin
    bit r_rst, r_sv, r_sof, r_sin, r_rdy, r_clr;

    drive(1, 0, 0, 0, 0, 0);

    // ---------------- table-driven vectors ----------------
    add(1, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
    add_frame(0, 0, 1);
    add(0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 0));
    add_frame(1, 0, 0);
    add(0, 0, 0, 0, 0, 0, ev(0, 1, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, 1, ev(0, 1, 0, 0, 0, 0));
    add(0, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].sv, tbl[i].sof, tbl[i].sin, tbl[i].rdy, tbl[i].clr);
      tick();
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // ---------------- gaps: counter holds while SIN_VALID=0 ----------------
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive(0, 1, i == 0, 0, 1, 0);
      tick();
      check("gap_bit", ev((i == N - 1) && !PAR_EN, 0, 0, 0, 1, i + 1));
      if (i < N - 1) begin
        drive(0, 0, 0, 0, 1, 0);
        tick();
        check("gap_hold", ev(0, 0, 0, 0, 1, i + 1));
      end
    end
`ifdef S_P_PARITY_CHECK_EN
    drive(0, 1, 0, 0, 1, 0);
    tick();
    check("gap_par_latch", ev(1, 0, 0, 0, 1, N));
`endif
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("gap_fv", ev(0, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check("gap_consumed", ev(0, 0, 0, 0, 0, 0));

    // ---------------- READY rises in the LATCH cycle ----------------
    do_reset();
    send_bits(8'h3C, N, 1, 0);
`ifdef S_P_PARITY_CHECK_EN
    send_bits(8'h00, 1, 0, 0);
`endif
    check("a_latch", ev(1, 0, 0, 0, 1, N));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("a_valid", ev(0, 1, 0, 0, 0, 0));
    send_bits(8'hC3, N, 1, 0);
`ifdef S_P_PARITY_CHECK_EN
    send_bits(8'h00, 1, 0, 0);
`endif
    check("b_held", ev(0, 1, 0, 0, 1, N));
    drive(0, 0, 0, 0, 1, 0);
    #1;
    check("rdy_in_latch", ev(1, 1, 0, 0, 1, N));
    tick();
    check("rdy_after_latch", ev(0, 1, 0, 0, 0, 0));
    tick();
    check("rdy_consumed", ev(0, 0, 0, 0, 0, 0));

    // ---------------- SOF after 5 bits restarts the frame ----------------
    do_reset();
    send_bits(8'h00, 5, 1, 1);
    check("pre_abort", ev(0, 0, 0, 0, 1, 5));
    send_bits(8'h00, 1, 1, 1);
    check("abort_cnt", ev(0, 0, 0, 0, 1, 1));
    send_bits(8'h00, N - 2, 0, 1);
    check("abort_no_latch", ev(0, 0, 0, 0, 1, N - 1));
    send_bits(8'h00, 1, 0, 1);
    check("abort_done", ev(!PAR_EN, 0, 0, 0, 1, N));
`ifdef S_P_PARITY_CHECK_EN
    send_bits(8'h00, 1, 0, 1);
    check("abort_par_latch", ev(1, 0, 0, 0, 1, N));
`endif

    // ---------------- RST mid-frame ----------------
    do_reset();
    send_bits(8'h0F, N, 1, 0);
`ifdef S_P_PARITY_CHECK_EN
    send_bits(8'h00, 1, 0, 0);
`endif
    drive(0, 0, 0, 0, 0, 0);
    tick();
    send_bits(8'h00, 4, 1, 0);
    check("mid_frame", ev(0, 1, 0, 0, 1, 4));
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check("rst_mid", ev(0, 0, 0, 0, 0, 0));

    // ---------------- parity on 8'hA5 ----------------
    do_reset();
    send_bits(8'hA5, N, 1, 1);
`ifdef S_P_PARITY_CHECK_EN
    check("par_wait", ev(0, 0, 0, 0, 1, N));
    send_bits(8'h00, 1, 0, 1);
    check("par_good", ev(1, 0, 0, 0, 1, N));
    do_reset();
    send_bits(8'hA5, N, 1, 1);
    send_bits(8'h01, 1, 0, 1);
    check("par_err", ev(0, 0, 0, 1, 0, 0));
    drive(0, 0, 0, 0, 1, 0);
    tick();
    check("par_err_pulse", ev(0, 0, 0, 0, 0, 0));
`else
    check("a5_latch", ev(1, 0, 0, 0, 1, N));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("a5_valid", ev(0, 1, 0, 0, 0, 0));
`endif

    // ---------------- randomized run against the reference ----------------
    drive(1, 0, 0, 0, 0, 0);
    tick();
    model_step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_sv  = ($urandom_range(0, 9) < 7);
      r_sof = ($urandom_range(0, 14) == 0);
      r_sin = 1'($urandom_range(0, 1));
      r_rdy = ($urandom_range(0, 2) == 0);
      r_clr = ($urandom_range(0, 19) == 0);
      drive(r_rst, r_sv, r_sof, r_sin, r_rdy, r_clr);
      tick();
      model_step(r_rst, r_sv, r_sof, r_sin, r_rdy, r_clr);
      check($sformatf("rand[%0d]", c), ev(m_le(r_rdy), m_fv, m_ovr, m_perr, m_cnt != 0, m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
